// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache: miss-controller states and
// address-split width helpers.
package cache_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_REFILL
    } state_t;

    // Byte offset plus word-select bits.
    function automatic int offset_bits(input int words_per_block);
        return $clog2(words_per_block) + 2;
    endfunction

    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int addr_bits, input int sets, input int words_per_block);
        return addr_bits - index_bits(sets) - offset_bits(words_per_block);
    endfunction

endpackage

// File: rtl/cache_set_array.sv
// Line storage (valid, dirty, tag, block) and round-robin victim pointers for every set.
// Reads are combinational on the index; writes cover word store, line load and pointer advance.
module cache_set_array
    import cache_pkg::*;
#(
    parameter int SETS       = 32,
    parameter int WAYS       = 2,
    parameter int IDX_W      = 5,
    parameter int TAG_W      = 23,
    parameter int WAY_W      = 1,
    parameter int WSEL_W     = 2,
    parameter int BLOCK_BITS = 128
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [IDX_W-1:0]           index,
    output logic [WAYS-1:0]            rd_valid,
    output logic [WAYS-1:0]            rd_dirty,
    output logic [WAYS*TAG_W-1:0]      rd_tag,
    output logic [WAYS*BLOCK_BITS-1:0] rd_data,
    output logic [WAY_W-1:0]           rd_ptr,
    input  logic                       wr_word_en,
    input  logic [WAY_W-1:0]           wr_way,
    input  logic [WSEL_W-1:0]          wr_word,
    input  logic [31:0]                wr_data,
    input  logic                       ld_en,
    input  logic [WAY_W-1:0]           ld_way,
    input  logic [TAG_W-1:0]           ld_tag,
    input  logic [BLOCK_BITS-1:0]      ld_data,
    input  logic                       ptr_adv
);

    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       dirty_q [SETS];
    logic [WAY_W-1:0]      ptr_q   [SETS];
    logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
    logic [BLOCK_BITS-1:0] data_q  [SETS][WAYS];

    for (genvar w = 0; w < WAYS; w++) begin : g_rd
        assign rd_valid[w]                         = valid_q[index][w];
        assign rd_dirty[w]                         = dirty_q[index][w];
        assign rd_tag[w*TAG_W +: TAG_W]            = tag_q[index][w];
        assign rd_data[w*BLOCK_BITS +: BLOCK_BITS] = data_q[index][w];
    end

    assign rd_ptr = ptr_q[index];

    // A reset mid-transaction must leave every line invalid, so all state clears here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    data_q[s][w] <= '0;
                end
            end
        end else begin
            if (wr_word_en) begin
                data_q[index][wr_way][{wr_word, 5'd0} +: 32] <= wr_data;
                dirty_q[index][wr_way]                       <= 1'b1;
            end
            if (ld_en) begin
                data_q[index][ld_way]  <= ld_data;
                tag_q[index][ld_way]   <= ld_tag;
                valid_q[index][ld_way] <= 1'b1;
                dirty_q[index][ld_way] <= 1'b0;
            end
            if (ptr_adv) begin
                if (ptr_q[index] == WAY_W'(WAYS - 1))
                    ptr_q[index] <= '0;
                else
                    ptr_q[index] <= ptr_q[index] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_assoc.sv
// N-way set-associative write-back cache with integrated miss controller (write-back then refill).
// Define CACHE_STATS_EN to build the saturating hit/miss counters; otherwise both read as 0.
module cache_assoc
    import cache_pkg::*;
#(
    parameter int ADDR_BITS       = 32,
    parameter int SETS            = 32,
    parameter int WAYS            = 2,
    parameter int WORDS_PER_BLOCK = 4,
    localparam int BLOCK_BITS     = 32 * WORDS_PER_BLOCK
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_BITS-1:0]  cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_rvalid,
    output logic [31:0]           cpu_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [BLOCK_BITS-1:0] mem_wdata,
    input  logic [BLOCK_BITS-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int OFF_W  = offset_bits(WORDS_PER_BLOCK);
    localparam int IDX_W  = index_bits(SETS);
    localparam int TAG_W  = tag_bits(ADDR_BITS, SETS, WORDS_PER_BLOCK);
    localparam int WSEL_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_t                 state;
    logic                   req_we;
    logic [ADDR_BITS-1:0]   req_addr;
    logic [31:0]            req_wdata;
    logic [WAY_W-1:0]       victim_way;

    logic [TAG_W-1:0]       req_tag;
    logic [IDX_W-1:0]       req_index;
    logic [WSEL_W-1:0]      req_word;
    logic [ADDR_BITS-1:0]   req_block_addr;
    logic                   unused_byte_sel;

    logic [WAYS-1:0]            rd_valid;
    logic [WAYS-1:0]            rd_dirty;
    logic [WAYS*TAG_W-1:0]      rd_tag;
    logic [WAYS*BLOCK_BITS-1:0] rd_data;
    logic [WAY_W-1:0]           rd_ptr;

    logic                   hit;
    logic [WAY_W-1:0]       hit_way;
    logic [BLOCK_BITS-1:0]  hit_block;
    logic [31:0]            hit_word;
    logic                   victim_valid;
    logic                   victim_dirty;
    logic [TAG_W-1:0]       victim_tag;
    logic [BLOCK_BITS-1:0]  victim_block;

    logic                   wr_word_en;
    logic                   ld_en;

    assign req_tag         = req_addr[ADDR_BITS-1 -: TAG_W];
    assign req_index       = req_addr[OFF_W +: IDX_W];
    assign req_block_addr  = {req_tag, req_index, {OFF_W{1'b0}}};
    assign unused_byte_sel = ^req_addr[1:0];

    if (WORDS_PER_BLOCK > 1) begin : g_wsel
        assign req_word = req_addr[2 +: WSEL_W];
    end else begin : g_wsel_single
        assign req_word = '0;
    end

    cache_set_array #(
        .SETS       (SETS),
        .WAYS       (WAYS),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W),
        .WAY_W      (WAY_W),
        .WSEL_W     (WSEL_W),
        .BLOCK_BITS (BLOCK_BITS)
    ) u_set_array (
        .clk        (clk),
        .reset_n    (reset_n),
        .index      (req_index),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .rd_ptr     (rd_ptr),
        .wr_word_en (wr_word_en),
        .wr_way     (hit_way),
        .wr_word    (req_word),
        .wr_data    (req_wdata),
        .ld_en      (ld_en),
        .ld_way     (victim_way),
        .ld_tag     (req_tag),
        .ld_data    (mem_rdata),
        .ptr_adv    (ld_en)
    );

    // At most one valid way can carry a given tag, so the last match is the only match.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (rd_valid[w] && (rd_tag[w*TAG_W +: TAG_W] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        hit_block    = '0;
        victim_block = '0;
        victim_tag   = '0;
        victim_valid = 1'b0;
        victim_dirty = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_way == WAY_W'(w))
                hit_block = rd_data[w*BLOCK_BITS +: BLOCK_BITS];
            if (rd_ptr == WAY_W'(w)) begin
                victim_block = rd_data[w*BLOCK_BITS +: BLOCK_BITS];
                victim_tag   = rd_tag[w*TAG_W +: TAG_W];
                victim_valid = rd_valid[w];
                victim_dirty = rd_dirty[w];
            end
        end
    end

    assign hit_word   = hit_block[{req_word, 5'd0} +: 32];
    assign wr_word_en = (state == S_COMPARE) && hit && req_we;
    assign ld_en      = (state == S_REFILL) && mem_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cpu_ready  <= 1'b1;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            victim_way <= '0;
        end else begin
            cpu_rvalid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        req_we    <= cpu_we;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        cpu_ready <= 1'b0;
                        state     <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (hit) begin
                        cpu_rvalid <= 1'b1;
                        if (!req_we)
                            cpu_rdata <= hit_word;
                        cpu_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        victim_way <= rd_ptr;
                        mem_req    <= 1'b1;
                        if (victim_valid && victim_dirty) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {victim_tag, req_index, {OFF_W{1'b0}}};
                            mem_wdata <= victim_block;
                            state     <= S_WRITEBACK;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= req_block_addr;
                            state    <= S_REFILL;
                        end
                    end
                end
                // mem_req stays high across the hand-off; only direction and address change.
                S_WRITEBACK: begin
                    if (mem_ack) begin
                        mem_we   <= 1'b0;
                        mem_addr <= req_block_addr;
                        state    <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= S_COMPARE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_q;
    logic [31:0] miss_q;
    logic        replay_q;

    // The COMPARE that follows a refill always hits and is not a new access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_q    <= '0;
            miss_q   <= '0;
            replay_q <= 1'b0;
        end else begin
            if (ld_en)
                replay_q <= 1'b1;
            else if (state == S_COMPARE)
                replay_q <= 1'b0;
            if ((state == S_COMPARE) && hit && !replay_q && (hit_q != 32'hFFFF_FFFF))
                hit_q <= hit_q + 32'd1;
            if ((state == S_COMPARE) && !hit && (miss_q != 32'hFFFF_FFFF))
                miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_assoc.sv
// Directed bench for cache_assoc: refill, hits, store/write-back eviction, round-robin and async reset.
module tb_cache_assoc;

`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk;
    logic         reset_n;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic         cpu_ready;
    logic         cpu_rvalid;
    logic [31:0]  cpu_rdata;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ack;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int n_cmp;
    int n_err;
    int ack_delay;
    int req_cycles;
    int n_wb;
    int n_refill;
    logic [31:0]  last_wb_addr;
    logic [127:0] last_wb_data;
    logic [31:0]  last_refill_addr;

    localparam logic [127:0] BLK_A  = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hDEADBEEF, 32'hA0A0A0A0};
    localparam logic [127:0] BLK_A2 = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hCAFEF00D, 32'hA0A0A0A0};
    localparam logic [127:0] BLK_B  = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'h30301111, 32'hB0B0B0B0};
    localparam logic [127:0] BLK_C  = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'h50502222, 32'hC0C0C0C0};

    cache_assoc dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one access and play the memory side until cpu_rvalid; exp_lat counts edges after acceptance.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic [31:0] exp_rdata, input string tag);
        int  wait_cnt;
        bit  done;
        wait_cnt   = 0;
        done       = 1'b0;
        req_cycles = 0;
        @(negedge clk);
        check({tag, "_ready"}, cpu_ready, 1'b1);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            if (cpu_rvalid) begin
                done = 1'b1;
                check({tag, "_lat"}, i, exp_lat);
                if (!we)
                    check({tag, "_rdata"}, cpu_rdata, exp_rdata);
            end
            mem_ack = 1'b0;
            if (mem_req) begin
                req_cycles++;
                if (wait_cnt == ack_delay) begin
                    if (mem_we) begin
                        n_wb++;
                        last_wb_addr = mem_addr;
                        last_wb_data = mem_wdata;
                    end else begin
                        n_refill++;
                        last_refill_addr = mem_addr;
                    end
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
        if (!done)
            check({tag, "_timeout"}, 1'b0, 1'b1);
    endtask

    initial begin
        bit seen;
        bit rv;
        n_cmp = 0;
        n_err = 0;
        n_wb = 0;
        n_refill = 0;
        ack_delay = 0;
        req_cycles = 0;
        last_wb_addr = '0;
        last_wb_data = '0;
        last_refill_addr = '0;
        reset_n   = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", cpu_ready, 1'b1);
        check("rst_rvalid", cpu_rvalid, 1'b0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 128'h0);
        check("rst_hits", hit_count, 32'h0);
        check("rst_misses", miss_count, 32'h0);
        reset_n = 1'b1;

        // Cold miss on 0x104, refill after 3 wait cycles.
        ack_delay = 3;
        mem_rdata = BLK_A;
        access(1'b0, 32'h104, 32'h0, 6, 32'hDEADBEEF, "miss104");
        check("miss104_refills", n_refill, 1);
        check("miss104_refill_addr", last_refill_addr, 32'h100);
        check("miss104_wbs", n_wb, 0);
        check("miss104_misses", miss_count, STATS ? 32'd1 : 32'd0);
        check("miss104_hits", hit_count, 32'd0);

        access(1'b0, 32'h104, 32'h0, 1, 32'hDEADBEEF, "hit104");
        check("hit104_no_mem", req_cycles, 0);
        check("hit104_hits", hit_count, STATS ? 32'd1 : 32'd0);

        access(1'b0, 32'h108, 32'h0, 1, 32'hA2A2A2A2, "hit108");
        access(1'b1, 32'h104, 32'hCAFEF00D, 1, 32'h0, "st104");
        check("st104_no_mem", req_cycles, 0);
        access(1'b0, 32'h104, 32'h0, 1, 32'hCAFEF00D, "ld104_after_st");

        // Clean miss on 0x304 with zero-wait memory fills way 1.
        ack_delay = 0;
        mem_rdata = BLK_B;
        access(1'b0, 32'h304, 32'h0, 3, 32'h30301111, "miss304");
        check("miss304_refill_addr", last_refill_addr, 32'h300);
        check("miss304_wbs", n_wb, 0);

        // 0x504 evicts dirty way 0: write-back of 0x100 then refill of 0x500.
        ack_delay = 1;
        mem_rdata = BLK_C;
        access(1'b0, 32'h504, 32'h0, 6, 32'h50502222, "miss504");
        check("miss504_wbs", n_wb, 1);
        check("miss504_wb_addr", last_wb_addr, 32'h100);
        check("miss504_wb_data", last_wb_data, BLK_A2);
        check("miss504_refills", n_refill, 3);
        check("miss504_refill_addr", last_refill_addr, 32'h500);
        check("miss504_misses", miss_count, STATS ? 32'd3 : 32'd0);

        access(1'b0, 32'h304, 32'h0, 1, 32'h30301111, "hit304");
        check("hit304_no_mem", req_cycles, 0);
        check("hit304_hits", hit_count, STATS ? 32'd5 : 32'd0);
        check("wdata_held", mem_wdata, BLK_A2);

        // Reset while a refill of 0x104 is outstanding.
        ack_delay = 1000;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h104;
        @(negedge clk);
        cpu_req = 1'b0;
        seen = 1'b0;
        rv   = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (cpu_rvalid) rv = 1'b1;
            if (mem_req) seen = 1'b1;
        end
        check("rstmid_req_seen", seen, 1'b1);
        check("rstmid_we", mem_we, 1'b0);
        check("rstmid_addr", mem_addr, 32'h100);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_req_drop", mem_req, 1'b0);
        check("rstmid_ready", cpu_ready, 1'b1);
        check("rstmid_wdata", mem_wdata, 128'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cpu_rvalid) rv = 1'b1;
        end
        check("rstmid_no_rvalid", rv, 1'b0);
        check("rstmid_hits", hit_count, 32'h0);
        check("rstmid_misses", miss_count, 32'h0);
        reset_n = 1'b1;

        // Former dirty contents are gone: clean miss, no write-back.
        ack_delay = 0;
        mem_rdata = BLK_A;
        access(1'b0, 32'h104, 32'h0, 3, 32'hDEADBEEF, "post_rst104");
        check("post_rst_refills", n_refill, 4);
        check("post_rst_refill_addr", last_refill_addr, 32'h100);
        check("post_rst_wbs", n_wb, 1);
        check("post_rst_misses", miss_count, STATS ? 32'd1 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_assoc.md
# cache_assoc

Parametrised N-way set-associative write-back cache with an integrated miss controller. It sits between the CPU load/store port and the block-wide memory port. Hits complete in one cycle after acceptance. Misses run a dirty-victim write-back followed by a block refill over a req/ack memory handshake, then replay the access.

## Interface
- `ADDR_BITS`, 32: byte-address width.
- `SETS`, 32: number of sets; power of 2.
- `WAYS`, 2: associativity; power of 2, at least 1.
- `WORDS_PER_BLOCK`, 4: 32-bit words per line; power of 2. `BLOCK_BITS = 32*WORDS_PER_BLOCK`.
- Address split:
  - [1:0]: byte, ignored.
  - Next `log2(WORDS_PER_BLOCK)` bits: word select.
  - Next `log2(SETS)` bits: index.
  - Remaining bits: tag.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: access request.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in `ADDR_BITS`: byte address.
- `cpu_wdata` in 32: store data.
- `cpu_ready` out 1: request accepted when `cpu_req && cpu_ready`.
- `cpu_rvalid` out 1: one-cycle completion pulse, for loads and stores.
- `cpu_rdata` out 32: load data, valid with `cpu_rvalid`.
- `mem_req` out 1: memory transaction request.
- `mem_we` out 1: 1 = write-back, 0 = refill.
- `mem_addr` out `ADDR_BITS`: block-aligned byte address.
- `mem_wdata` out `BLOCK_BITS`: victim block.
- `mem_rdata` in `BLOCK_BITS`: refill block, sampled on `mem_ack`.
- `mem_ack` in 1: completes the current transaction.
- `hit_count` out 32: see Configuration.
- `miss_count` out 32: see Configuration.

## Operation
- Per line: valid, dirty, tag, block. Per set: victim pointer, `log2(WAYS)` bits.
- FSM states:
  - **IDLE**: `cpu_ready=1`. An accepted request is registered (we, addr, wdata) and the FSM moves to COMPARE.
  - **COMPARE**: tag matched against all ways of the indexed set; at most one valid way can match.
    - Hit, load: `cpu_rvalid=1`, `cpu_rdata` = selected word.
    - Hit, store: selected word written, line dirty set, `cpu_rvalid=1`.
    - Both hit cases return to IDLE.
    - Miss: victim = way at the set pointer. Victim valid and dirty → WRITEBACK; otherwise → REFILL.
  - **WRITEBACK**: `mem_req=1`, `mem_we=1`, `mem_addr` = {victim tag, index, zeros}, `mem_wdata` = victim block. Held stable until `mem_ack`, then → REFILL.
  - **REFILL**: `mem_req=1`, `mem_we=0`, `mem_addr` = {request tag, index, zeros}. On `mem_ack`:
    - Victim way loaded with `mem_rdata`, request tag, valid=1, dirty=0.
    - Set pointer advances by 1, mod `WAYS`.
    - → COMPARE, which now hits and completes the access.
- Each `mem_ack` cycle ends exactly one transaction. WRITEBACK→REFILL may keep `mem_req` high; `mem_we` and `mem_addr` change on the cycle after the ack.
- `mem_ack` outside WRITEBACK/REFILL is ignored.
- `cpu_req` while `cpu_ready=0` is ignored; the CPU must hold it.
- Invalid ways are not preferred as victims; round-robin order only.

## Timing
- Reset values:
  - `cpu_ready=1`, `cpu_rvalid=0`, `cpu_rdata=0`.
  - `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
  - Counters 0.
  - All valid/dirty bits, tags and pointers 0; FSM in IDLE.
- Hit: accepted at edge N, `cpu_rvalid` during cycle N+1, `cpu_ready` high again in cycle N+2.
- Clean miss: `cpu_rvalid` 2 cycles after the refill ack cycle (REFILL → COMPARE).
- Dirty miss: write-back and refill serialised; total latency = 1 + WB wait + refill wait + 1.
- Zero-wait memory (ack in the first request cycle): clean miss completes in cycle N+3.
- Back-to-back hits: one access per 2 cycles.
- `reset_n` asserted mid-transaction: `mem_req` drops asynchronously. Outstanding access lost, no `cpu_rvalid`, all lines invalid.
- Block data never goes X on outputs: `mem_wdata` holds its last value outside WRITEBACK.

## Configuration
- `CACHE_STATS_EN` defined:
  - `hit_count` increments on each COMPARE hit, excluding the post-refill replay.
  - `miss_count` increments on each COMPARE miss.
  - Both saturate at `32'hFFFF_FFFF`.
- Undefined: both ports driven constant 0 and no counter flops exist. Port list unchanged.

## Structure
- Package `cache_pkg`: FSM state enum (`S_IDLE`, `S_COMPARE`, `S_WRITEBACK`, `S_REFILL`), plus address-split width functions (`offset_bits`, `index_bits`, `tag_bits`).
- Sub-module `cache_set_array`: line storage and victim pointers for all sets. Read-indexed combinationally; write ports for word store, line load and pointer advance.
- Top module holds the FSM, request register, tag compare/hit-way encode and counters.

## Test plan
Defaults: `SETS=32`, `WAYS=2`, `WORDS_PER_BLOCK=4`. Addresses 0x104, 0x304 and 0x504 all map to index 16, with tags 0, 1 and 2.
- Reset, then load 0x104 with memory returning word1=0xDEADBEEF and ack after 3 cycles → one refill at `mem_addr` 0x100, then `cpu_rdata`=0xDEADBEEF. `miss_count`=1.
- Repeat load 0x104 → `cpu_rvalid` at N+1, no `mem_req`, `hit_count`=1.
- Store 0xCAFEF00D to 0x104, then load 0x304, then load 0x504 → the third access evicts way 0: write-back at `mem_addr` 0x100 with word1 = 0xCAFEF00D, then refill at 0x500.
- Load 0x304 after the above → hit. Round-robin left way 1 (tag 1) resident.
- Assert `reset_n` during REFILL with `mem_req` high → `mem_req`=0 immediately, no `cpu_rvalid`. Next load of 0x104 misses.
- Build without `CACHE_STATS_EN` and run the same traffic → `hit_count` and `miss_count` stay 0; all other responses identical.
